// File: rtl/writeback_stage_if.sv
// Bus between the MEM stage and the writeback stage: MEM-stage result in,
// register-file write port and EX-stage forwarding bus out.
interface writeback_stage_if #(
  parameter int XLEN      = 32,
  parameter int NREG_BITS = 5
);
  logic                 mem_valid;
  logic                 mem_reg_write;
  logic [NREG_BITS-1:0] mem_rd;
  logic [1:0]           mem_sel;
  logic [XLEN-1:0]      mem_alu_result;
  logic [XLEN-1:0]      mem_pc_plus4;
  logic [XLEN-1:0]      mem_load_word;
  logic [2:0]           mem_funct3;

  logic [NREG_BITS-1:0] write_addr;
  logic                 write_enable;
  logic [XLEN-1:0]      write_data;
  logic                 fwd_valid;
  logic [NREG_BITS-1:0] fwd_rd;
  logic [XLEN-1:0]      fwd_data;
  logic                 load_err;

  modport master (
    output mem_valid, mem_reg_write, mem_rd, mem_sel,
           mem_alu_result, mem_pc_plus4, mem_load_word, mem_funct3,
    input  write_addr, write_enable, write_data,
           fwd_valid, fwd_rd, fwd_data, load_err
  );

  modport slave (
    input  mem_valid, mem_reg_write, mem_rd, mem_sel,
           mem_alu_result, mem_pc_plus4, mem_load_word, mem_funct3,
    output write_addr, write_enable, write_data,
           fwd_valid, fwd_rd, fwd_data, load_err
  );
endinterface

// File: rtl/writeback_stage.sv
// rv32i writeback stage: registers the MEM result, aligns/extends loads and
// drives the register-file write port once per retired instruction.
// Optional macro WB_INSTRET_EN adds a 64-bit retired-instruction counter.
module writeback_stage #(
  parameter int XLEN      = 32,
  parameter int NREG_BITS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  writeback_stage_if.slave  wb_if
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]       instret
`endif
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic                 r_valid;
  logic                 r_done;
  logic                 r_reg_write;
  logic [NREG_BITS-1:0] r_rd;
  logic [1:0]           r_sel;
  logic [XLEN-1:0]      r_alu_result;
  logic [XLEN-1:0]      r_pc_plus4;
  logic [XLEN-1:0]      r_load_word;
  logic [2:0]           r_funct3;

  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [XLEN-1:0]      w_load_data;
  logic                 w_funct3_bad;
  logic                 w_err;
  logic                 w_commit;
  logic                 w_write_enable;
  logic [XLEN-1:0]      w_src_data;

  // WB pipeline register; r_done marks that the held instruction already had its commit cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= {NREG_BITS{1'b0}};
      r_sel        <= 2'b00;
      r_alu_result <= {XLEN{1'b0}};
      r_pc_plus4   <= {XLEN{1'b0}};
      r_load_word  <= {XLEN{1'b0}};
      r_funct3     <= 3'b000;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (!stall) begin
      r_valid      <= wb_if.mem_valid;
      r_done       <= 1'b0;
      r_reg_write  <= wb_if.mem_reg_write;
      r_rd         <= wb_if.mem_rd;
      r_sel        <= wb_if.mem_sel;
      r_alu_result <= wb_if.mem_alu_result;
      r_pc_plus4   <= wb_if.mem_pc_plus4;
      r_load_word  <= wb_if.mem_load_word;
      r_funct3     <= wb_if.mem_funct3;
    end else begin
      r_done <= 1'b1;
    end
  end

  // Byte lane selected by the low address bits
  always_comb begin
    w_byte = 8'h00;
    case (r_alu_result[1:0])
      2'b00:   w_byte = r_load_word[7:0];
      2'b01:   w_byte = r_load_word[15:8];
      2'b10:   w_byte = r_load_word[23:16];
      2'b11:   w_byte = r_load_word[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  // Halfword misalignment is trapped upstream, so address bit 0 is ignored here
  assign w_half = r_alu_result[1] ? r_load_word[31:16] : r_load_word[15:0];

  // Load extension by funct3
  always_comb begin
    w_load_data  = {XLEN{1'b0}};
    w_funct3_bad = 1'b0;
    case (r_funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      3'b010:  w_load_data = r_load_word;
      default: w_funct3_bad = 1'b1;
    endcase
  end

  // Writeback source select; the reserved encoding writes nothing
  always_comb begin
    w_src_data = {XLEN{1'b0}};
    case (r_sel)
      SEL_ALU:  w_src_data = r_alu_result;
      SEL_LOAD: w_src_data = w_load_data;
      SEL_PC4:  w_src_data = r_pc_plus4;
      default:  w_src_data = {XLEN{1'b0}};
    endcase
  end

  assign w_err = r_valid & ((r_sel == 2'b11) | ((r_sel == SEL_LOAD) & w_funct3_bad));
  assign w_commit = r_valid & ~r_done & ~w_err;
  assign w_write_enable = w_commit & r_reg_write & (r_rd != {NREG_BITS{1'b0}});

  assign wb_if.write_enable = w_write_enable;
  assign wb_if.write_addr   = r_valid ? r_rd : {NREG_BITS{1'b0}};
  assign wb_if.write_data   = r_valid ? w_src_data : {XLEN{1'b0}};
  assign wb_if.load_err     = w_err & ~r_done;

  assign wb_if.fwd_valid = wb_if.write_enable;
  assign wb_if.fwd_rd    = wb_if.write_addr;
  assign wb_if.fwd_data  = wb_if.write_data;

`ifdef WB_INSTRET_EN
  // Retired-instruction counter; counts every commit, including rd=x0 and no-write ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= 64'd0;
    end else if (w_commit) begin
      instret <= instret + 64'd1;
    end else begin
      instret <= instret;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: ALU/load/JAL writes,
// x0 suppression, stall/flush single-write behaviour, errors and async reset.
module tb_writeback_stage;

  logic clk;
  logic rst_n;
  logic stall;
  logic flush;
  int   compared;
  int   mismatched;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  writeback_stage_if #(.XLEN(32), .NREG_BITS(5)) bus ();

  writeback_stage #(.XLEN(32), .NREG_BITS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .wb_if (bus)
`ifdef WB_INSTRET_EN
    ,
    .instret (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [31:0] word,
                       input logic [2:0] f3);
    bus.mem_valid      = v;
    bus.mem_reg_write  = rw;
    bus.mem_rd         = rd;
    bus.mem_sel        = sel;
    bus.mem_alu_result = alu;
    bus.mem_pc_plus4   = pc4;
    bus.mem_load_word  = word;
    bus.mem_funct3     = f3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_step(input string tag, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] exp);
    drive(1'b1, 1'b1, 5'd7, 2'b01, addr, 32'h0, 32'h80FF_7F01, f3);
    tick();
    chk({tag, "_we"}, {63'd0, bus.write_enable}, 64'd1);
    chk({tag, "_data"}, {32'd0, bus.write_data}, {32'd0, exp});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    stall      = 1'b0;
    flush      = 1'b0;
    rst_n      = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000);

    repeat (2) tick();
    chk("rst_we", {63'd0, bus.write_enable}, 64'd0);
    chk("rst_addr", {59'd0, bus.write_addr}, 64'd0);
    chk("rst_data", {32'd0, bus.write_data}, 64'd0);
    chk("rst_fwd_valid", {63'd0, bus.fwd_valid}, 64'd0);
    chk("rst_load_err", {63'd0, bus.load_err}, 64'd0);
`ifdef WB_INSTRET_EN
    chk("rst_instret", instret, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // ALU write followed by a bubble
    drive(1'b1, 1'b1, 5'd5, 2'b00, 32'h0000_1234, 32'h0, 32'h0, 3'b000);
    tick();
    chk("alu_we", {63'd0, bus.write_enable}, 64'd1);
    chk("alu_addr", {59'd0, bus.write_addr}, 64'd5);
    chk("alu_data", {32'd0, bus.write_data}, 64'h1234);
    chk("alu_fwd_valid", {63'd0, bus.fwd_valid}, 64'd1);
    chk("alu_fwd_rd", {59'd0, bus.fwd_rd}, 64'd5);
    chk("alu_fwd_data", {32'd0, bus.fwd_data}, 64'h1234);
    chk("alu_load_err", {63'd0, bus.load_err}, 64'd0);
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000);
    tick();
    chk("bubble_we", {63'd0, bus.write_enable}, 64'd0);
    chk("bubble_addr", {59'd0, bus.write_addr}, 64'd0);
    chk("bubble_data", {32'd0, bus.write_data}, 64'd0);

    // Loads from word 0x80FF_7F01
    load_step("lb_off3", 32'h0000_1003, 3'b000, 32'hFFFF_FF80);
    load_step("lbu_off3", 32'h0000_1003, 3'b100, 32'h0000_0080);
    load_step("lb_off1", 32'h0000_1001, 3'b000, 32'h0000_007F);
    load_step("lh_off2", 32'h0000_1002, 3'b001, 32'hFFFF_80FF);
    load_step("lh_off3", 32'h0000_1003, 3'b001, 32'hFFFF_80FF);
    load_step("lhu_off0", 32'h0000_1000, 3'b101, 32'h0000_7F01);
    load_step("lw", 32'h0000_1002, 3'b010, 32'h80FF_7F01);

    // x0 is never written; JAL writes the link value
    drive(1'b1, 1'b1, 5'd0, 2'b00, 32'h0000_DEAD, 32'h0, 32'h0, 3'b000);
    tick();
    chk("x0_we", {63'd0, bus.write_enable}, 64'd0);
    chk("x0_fwd_valid", {63'd0, bus.fwd_valid}, 64'd0);
    drive(1'b1, 1'b1, 5'd1, 2'b10, 32'h0000_0055, 32'h0000_0104, 32'h0, 3'b000);
    tick();
    chk("jal_we", {63'd0, bus.write_enable}, 64'd1);
    chk("jal_addr", {59'd0, bus.write_addr}, 64'd1);
    chk("jal_data", {32'd0, bus.write_data}, 64'h104);

    // Capture rd=3 then stall three cycles: one write only
    drive(1'b1, 1'b1, 5'd3, 2'b00, 32'h0000_0033, 32'h0, 32'h0, 3'b000);
    tick();
    chk("stall_first_we", {63'd0, bus.write_enable}, 64'd1);
`ifdef WB_INSTRET_EN
    chk("stall_instret_before", instret, 64'd10);
`endif
    stall = 1'b1;
    drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h0000_0099, 32'h0, 32'h0, 3'b000);
    tick();
    chk("stall1_we", {63'd0, bus.write_enable}, 64'd0);
    chk("stall1_addr", {59'd0, bus.write_addr}, 64'd3);
    chk("stall1_data", {32'd0, bus.write_data}, 64'h33);
    tick();
    chk("stall2_we", {63'd0, bus.write_enable}, 64'd0);
    tick();
    chk("stall3_we", {63'd0, bus.write_enable}, 64'd0);
`ifdef WB_INSTRET_EN
    chk("stall_instret_after", instret, 64'd11);
`endif

    // Flush while stalled wins and leaves a bubble
    flush = 1'b1;
    tick();
    chk("flush_we", {63'd0, bus.write_enable}, 64'd0);
    chk("flush_addr", {59'd0, bus.write_addr}, 64'd0);
    chk("flush_data", {32'd0, bus.write_data}, 64'd0);
    flush = 1'b0;
    stall = 1'b0;

    // Illegal load funct3: one-cycle error pulse, no write
    drive(1'b1, 1'b1, 5'd4, 2'b01, 32'h0000_1000, 32'h0, 32'h80FF_7F01, 3'b011);
    tick();
    chk("f3err_pulse", {63'd0, bus.load_err}, 64'd1);
    chk("f3err_we", {63'd0, bus.write_enable}, 64'd0);
    stall = 1'b1;
    tick();
    chk("f3err_held", {63'd0, bus.load_err}, 64'd0);
    chk("f3err_held_we", {63'd0, bus.write_enable}, 64'd0);
    stall = 1'b0;

    // Reserved writeback select
    drive(1'b1, 1'b1, 5'd4, 2'b11, 32'h0000_0044, 32'h0, 32'h0, 3'b000);
    tick();
    chk("sel11_pulse", {63'd0, bus.load_err}, 64'd1);
    chk("sel11_we", {63'd0, bus.write_enable}, 64'd0);
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000);
    tick();
    chk("sel11_after", {63'd0, bus.load_err}, 64'd0);
`ifdef WB_INSTRET_EN
    chk("err_instret", instret, 64'd11);
`endif

    // Asynchronous reset while a write is being presented
    drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h0000_0099, 32'h0, 32'h0, 3'b000);
    tick();
    chk("prerst_we", {63'd0, bus.write_enable}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_we", {63'd0, bus.write_enable}, 64'd0);
    chk("midrst_addr", {59'd0, bus.write_addr}, 64'd0);
    chk("midrst_data", {32'd0, bus.write_data}, 64'd0);
    chk("midrst_fwd_valid", {63'd0, bus.fwd_valid}, 64'd0);
`ifdef WB_INSTRET_EN
    chk("midrst_instret", instret, 64'd0);
`endif
    tick();
    drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("postrst_we", {63'd0, bus.write_enable}, 64'd0);
    chk("postrst_addr", {59'd0, bus.write_addr}, 64'd0);
`ifdef WB_INSTRET_EN
    chk("postrst_instret", instret, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final stage of the rv32i pipelined core, the producer side of the register file write port.
- Registers the MEM-stage result.
- Aligns and extends load data, and selects the writeback source.
- Drives write_addr/write_enable/write_data exactly once per retired instruction; the same values go out on a forwarding bus for EX-stage bypass.

Parameters:
XLEN, 32, datapath width (only 32 supported)
NREG_BITS, 5, register index width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold WB register contents
flush  input  1  load a bubble into WB at next edge
mem_valid  input  1  MEM-stage slot holds a real instruction
mem_reg_write  input  1  instruction writes rd
mem_rd  input  5  destination register
mem_sel  input  2  00 ALU, 01 load, 10 pc+4, 11 reserved
mem_alu_result  input  32  ALU result / load address
mem_pc_plus4  input  32  link value for JAL/JALR
mem_load_word  input  32  raw aligned word from data memory
mem_funct3  input  3  load size/sign code
write_addr  output  5  register file write index
write_enable  output  1  register file write strobe
write_data  output  32  register file write value
fwd_valid  output  1  forwarding bus valid (equals write_enable)
fwd_rd  output  5  forwarding destination
fwd_data  output  32  forwarding value
load_err  output  1  one-cycle pulse: illegal load funct3 or mem_sel 11

Behaviour:
- Reset: rst_n low asynchronously clears the WB register.
  - Clears wb_valid and wb_done.
  - All outputs 0; write_addr = 0, write_data = 0.
- Capture: at posedge, flush=1 loads a bubble (wb_valid=0), regardless of stall.
  - Else if stall=0, all mem_* inputs are captured and wb_done is cleared.
  - Else (stall=1) contents are held and wb_done is set to 1.
- Commit condition: commit = wb_valid & ~wb_done & ~err.
  - write_enable = commit & wb_reg_write & (wb_rd != 0).
  - x0 is never written.
- Latency: an instruction captured at edge N presents write_enable during cycle N..N+1; the register file updates at edge N+1.
- Single write per instruction: while held by stall, write_enable is high only in the first WB cycle, and low afterwards until a new capture.
- Source select:
  - ALU → wb_alu_result.
  - pc+4 → wb_pc_plus4.
  - load → aligned value.
- Load alignment, offset = wb_alu_result[1:0]:
  - 000 LB: byte[offset], sign-extended.
  - 100 LBU: byte[offset], zero-extended.
  - 001 LH: half[offset[1]], sign-extended.
  - 101 LHU: half[offset[1]], zero-extended.
  - 010 LW: full word; offset ignored.
  - offset[0] is ignored for halfwords (misalignment is trapped upstream).
- Errors: err = wb_valid & (mem_sel==11 | (sel==load & funct3 in {011,110,111})).
  - load_err pulses high for exactly one cycle (first WB cycle only).
  - No write occurs.
- Idle outputs: write_data, write_addr and fwd_* are driven from WB contents whenever wb_valid. When not valid, write_data = 0 and write_addr = 0.
- Forwarding: fwd_valid = write_enable, fwd_rd = write_addr, fwd_data = write_data. The bus is combinational from the WB register; no extra latency.
- Simultaneous flush and stall: flush wins. The held instruction has already committed in its first cycle.
- Reset mid-stall: the pending write is discarded and nothing is written.

Optional Feature:
- Macro WB_INSTRET_EN.
- When defined:
  - Adds output instret [63:0], a retired-instruction counter. Reset value 0.
  - Increments by 1 on each posedge where commit=1, including instructions with reg_write=0 or rd=0.
  - Wraps from 2^64-1 to 0.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- ALU write, sel=00, rd=5, alu=0x0000_1234, reg_write=1, one cycle → write_enable=1, write_addr=5, write_data=0x1234 for one cycle; fwd_* identical.
- Loads with mem_load_word=0x80FF_7F01:
  - LB offset 3 → 0xFFFF_FF80.
  - LBU offset 3 → 0x0000_0080.
  - LH offset 2 → 0xFFFF_80FF.
  - LHU offset 0 → 0x0000_7F01.
  - LW → 0x80FF_7F01.
- x0 and JAL: rd=0 with reg_write=1 → write_enable stays 0. JAL sel=10, pc_plus4=0x104, rd=1 → write_data=0x104.
- Stall/flush:
  - Capture rd=3, then stall 3 cycles → write_enable high 1 cycle only.
  - flush=1 with stall=1 → next cycle wb_valid=0, no write.
  - With WB_INSTRET_EN, instret increments by exactly 1.
- Errors: funct3=011 with sel=01 → load_err 1-cycle pulse, write_enable 0. sel=11 → same.
- Reset mid-operation: assert rst_n=0 asynchronously mid-cycle while write_enable=1 → all outputs 0 immediately; no write after release; instret=0.
